// File: rtl/sampler_capture_ctrl.sv
// rtl/sampler_capture_ctrl.sv - decimating, optionally triggered sample capture into a linear buffer
// Config is latched on start; kept samples are written one cycle after their strobe.
module sampler_capture_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [7:0]        cfg_decim,
  input  logic              cfg_trig_mode,
  input  logic              trig_in,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic [1:0]        state,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sample_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            cur_state;
  state_t            nxt_state;
  logic [ADDR_W-1:0] len_q;
  logic [7:0]        decim_q;
  logic              mode_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [7:0]        dcnt;
  logic              trig_prev;

  logic arm;
  logic keep;
  logic drop;
  logic last;
  logic trig_fire;

  // Abort overrides every other request in the same cycle, including a start.
  assign arm  = cfg_start && !cfg_abort &&
                ((cur_state == ST_IDLE) || (cur_state == ST_DONE));
  assign keep = (cur_state == ST_CAPTURE) && s_valid && !cfg_abort && (dcnt == 8'd0);
  assign drop = (cur_state == ST_CAPTURE) && s_valid && !cfg_abort && (dcnt != 8'd0);
  assign last = keep && (wr_ptr == len_q);

  // Edge detect against the history register, so a level already high at arm is ignored.
  assign trig_fire = mode_q ? (trig_in && !trig_prev) : 1'b1;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    if (cfg_abort) begin
      nxt_state = ST_IDLE;
    end else begin
      case (cur_state)
        ST_IDLE:    if (cfg_start) nxt_state = ST_ARMED;
        ST_ARMED:   if (trig_fire) nxt_state = ST_CAPTURE;
        ST_CAPTURE: if (last)      nxt_state = ST_DONE;
        ST_DONE:    if (cfg_start) nxt_state = ST_ARMED;
        default:    nxt_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      len_q      <= '0;
      decim_q    <= '0;
      mode_q     <= 1'b0;
      wr_ptr     <= '0;
      dcnt       <= '0;
      trig_prev  <= 1'b0;
      sample_cnt <= '0;
      buf_we     <= 1'b0;
      buf_addr   <= '0;
      buf_wdata  <= '0;
    end else begin
      trig_prev <= trig_in;
      buf_we    <= keep;
      if (arm) begin
        len_q      <= cfg_len;
        decim_q    <= cfg_decim;
        mode_q     <= cfg_trig_mode;
        wr_ptr     <= '0;
        dcnt       <= '0;
        sample_cnt <= '0;
      end else if (keep) begin
        buf_addr   <= wr_ptr;
        buf_wdata  <= s_data;
        wr_ptr     <= wr_ptr + PTR_ONE;
        sample_cnt <= sample_cnt + CNT_ONE;
        dcnt       <= decim_q;
      end else if (drop) begin
        dcnt <= dcnt - 8'd1;
      end
    end
  end

  assign state = cur_state;
  assign busy  = (cur_state == ST_ARMED) || (cur_state == ST_CAPTURE);
  assign done  = (cur_state == ST_DONE);

endmodule

// File: doc/sampler_capture_ctrl.md
SAMPLER_CAPTURE_CTRL -- requirements
Module: sampler_capture_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, width of one sample word and of buf_wdata.
REQ-002 Parameter ADDR_W, default 10, capture buffer address width (max depth 2^ADDR_W words).
REQ-003 ACLK  in  1  sole clock; all state changes on rising edge.
REQ-004 ARESET  in  1  reset, asynchronous assert, active-high; released synchronously to ACLK by the parent.
REQ-005 cfg_start  in  1  one-cycle pulse from the AXI4-Lite control register; arms a capture.
REQ-006 cfg_abort  in  1  one-cycle pulse; cancels any capture.
REQ-007 cfg_len  in  ADDR_W  number of samples to capture minus one.
REQ-008 cfg_decim  in  8  decimation: keep 1 of every cfg_decim+1 valid samples.
REQ-009 cfg_trig_mode  in  1  0 = start immediately, 1 = wait for trig_in rising edge.
REQ-010 trig_in  in  1  trigger level, synchronous to ACLK.
REQ-011 s_valid  in  1  sample strobe from the sampler front end; no backpressure.
REQ-012 s_data  in  DATA_W  sample word, valid when s_valid=1.
REQ-013 buf_we  out  1  buffer write enable.
REQ-014 buf_addr  out  ADDR_W  buffer write address.
REQ-015 buf_wdata  out  DATA_W  buffer write data.
REQ-016 state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3; readable status.
REQ-017 busy  out  1  high in ARMED or CAPTURE.
REQ-018 done  out  1  high while in DONE.
REQ-019 sample_cnt  out  ADDR_W+1  samples written in the current/last capture.

Function
REQ-020 cfg_len, cfg_decim and cfg_trig_mode SHALL be latched on the accepted cfg_start; later config changes have no effect until the next start.
REQ-021 IDLE or DONE + cfg_start -> ARMED next cycle; sample_cnt, write pointer and decimation counter cleared to 0.
REQ-022 cfg_start in ARMED or CAPTURE SHALL be ignored.
REQ-023 ARMED, latched mode 0 -> CAPTURE on the following cycle unconditionally.
REQ-024 ARMED, latched mode 1 -> CAPTURE on the cycle after trig_in=1 with the registered previous trig_in=0; trig_in already high at arm time SHALL NOT trigger.
REQ-025 The trig_in history register SHALL update every cycle in every state.
REQ-026 CAPTURE: on s_valid with decimation counter=0 the sample is kept and the counter reloads to latched cfg_decim; on s_valid with counter>0 the counter decrements and the sample is dropped; the first valid sample in CAPTURE is always kept.
REQ-027 A kept sample SHALL appear as buf_we=1, buf_addr=write pointer, buf_wdata=s_data exactly one cycle after its s_valid (registered outputs); the pointer and sample_cnt then increment by 1.
REQ-028 s_valid outside CAPTURE SHALL be discarded with no effect on any counter.
REQ-029 When the kept sample has index equal to latched cfg_len, the state SHALL go to DONE in the same cycle its buf_we is asserted; no further writes occur.
REQ-030 cfg_len = 2^ADDR_W-1 SHALL fill the buffer exactly; sample_cnt reaches 2^ADDR_W without wrapping; buf_addr never wraps within one capture.
REQ-031 cfg_abort in any state -> IDLE next cycle; buf_we forced 0 from that cycle; sample_cnt holds its value.
REQ-032 cfg_abort and cfg_start in the same cycle: abort wins and the start is dropped.
REQ-033 done stays high in DONE until cfg_start or cfg_abort.
REQ-034 Decimation counter is 8 bits; cfg_decim=0 keeps every valid sample; 255 keeps 1 of 256.

Reset
REQ-035 ARESET asserted SHALL immediately force state=IDLE, buf_we=0, buf_addr=0, buf_wdata=0, busy=0, done=0, sample_cnt=0, decimation counter=0, and trig_in history=0.
REQ-036 Reset during CAPTURE SHALL abandon the capture with no buf_we pulse after assertion; the capture does not resume on release.

Verification
REQ-037 Immediate mode: cfg_len=3, cfg_decim=0, s_valid continuous with data 1,2,3,4,5 -> writes (addr,data) (0,1)(1,2)(2,3)(3,4); done=1; sample_cnt=4; value 5 never written.
REQ-038 Decimation: cfg_len=1, cfg_decim=2, s_data 10..15 on consecutive valids -> writes (0,10)(1,13), then DONE.
REQ-039 Trigger: mode 1, trig_in held high at start -> stays ARMED with no writes; trig_in 1->0->1 -> CAPTURE one cycle after the rising edge.
REQ-040 Abort: abort after 2 writes of cfg_len=7 -> IDLE next cycle, sample_cnt=2, no further buf_we; abort+start in the same cycle from DONE -> IDLE.
REQ-041 Full buffer: ADDR_W=4, cfg_len=15 -> 16 writes to addr 0..15, sample_cnt=16, DONE; a restart from DONE clears sample_cnt to 0.
REQ-042 Async reset mid-CAPTURE between clock edges -> all outputs at reset values before the next ACLK edge.
